rgb_seq_master: RTL and testbench

//  Bus initiator that programs the RGB LED driver peripheral without CPU help.

---
 rtl/rgb_seq_master.sv | 232 +++++++++++++++++++++++
 tb/tb_rgb_seq_master.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_seq_master.sv
// ----------------------------------------------------------------------------
// rgb_seq_master
//
// Bus initiator that programs the RGB LED driver peripheral without CPU help.
// After reset it walks a fixed init table (ctrl register plus SB_LEDDA_IP
// registers). Then it accepts colour commands over a valid/ready handshake.
// Each command becomes four register writes: PWRR, PWRG, PWRB, then ctrl.
//
// Every write takes two cycles:
//   strobe : bus_cs = bus_we = 1 with addr/din valid, for exactly one cycle
//   gap    : bus_cs = bus_we = 0 while addr/din hold their last values
//
// Configuration macro:
//   LED_BREATHE_EN  defined   : the init table also writes BCRR/BCFR (11 writes)
//                   undefined : the breathe registers keep their hardware
//                               defaults (9 writes); BCRR_VAL/BCFR_VAL unused
//
// Ports:
//   clk        in   1  system clock
//   rst        in   1  synchronous reset, active-high
//   cmd_valid  in   1  colour command present
//   cmd_ready  out  1  block idle; command accepted when cmd_valid & cmd_ready
//   cmd_r      in   8  red duty   -> LEDDPWRR
//   cmd_g      in   8  green duty -> LEDDPWRG
//   cmd_b      in   8  blue duty  -> LEDDPWRB
//   cmd_en     in   1  1: ctrl = 3'b111 (run), 0: ctrl = 3'b000 (LED off)
//   busy       out  1  ~cmd_ready
//   bus_cs     out  1  chip select strobe to the driver
//   bus_we     out  1  write enable (always equal to bus_cs)
//   bus_addr   out  5  [4]=1: LEDDA register addr[3:0]; [4]=0: ctrl register
//   bus_din    out  8  write data (ctrl writes use [2:0], rest zero)
// ----------------------------------------------------------------------------
module rgb_seq_master #(
  parameter logic [7:0] CR0_VAL  = 8'h81,  // LEDDCR0: LEDDEN=1, BRMSBEXT=01
  parameter logic [7:0] BR_VAL   = 8'h76,  // LEDDBR prescale low byte
  parameter logic [7:0] ONR_VAL  = 8'h00,  // LEDDONR blink on-time
  parameter logic [7:0] OFR_VAL  = 8'h00,  // LEDDOFR blink off-time
  parameter logic [7:0] BCRR_VAL = 8'h00,  // LEDDBCRR breathe-on ramp
  parameter logic [7:0] BCFR_VAL = 8'h00   // LEDDBCFR breathe-off ramp
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_r,
  input  logic [7:0] cmd_g,
  input  logic [7:0] cmd_b,
  input  logic       cmd_en,
  output logic       busy,
  output logic       bus_cs,
  output logic       bus_we,
  output logic [4:0] bus_addr,
  output logic [7:0] bus_din
);

  // Register addresses on the driver bus.
  localparam logic [4:0] A_CTRL = 5'h00;
  localparam logic [4:0] A_PWRR = 5'h11;
  localparam logic [4:0] A_PWRG = 5'h12;
  localparam logic [4:0] A_PWRB = 5'h13;
  localparam logic [4:0] A_BCRR = 5'h15;
  localparam logic [4:0] A_BCFR = 5'h16;
  localparam logic [4:0] A_CR0  = 5'h18;
  localparam logic [4:0] A_BR   = 5'h19;
  localparam logic [4:0] A_ONR  = 5'h1A;
  localparam logic [4:0] A_OFR  = 5'h1B;

`ifdef LED_BREATHE_EN
  localparam logic [3:0] INIT_LEN = 4'd11;
`else
  localparam logic [3:0] INIT_LEN = 4'd9;
`endif
  localparam logic [3:0] UPD_LEN = 4'd4;

  // The state always names the bus phase currently being driven. Reset parks
  // in INIT_GAP with step 0, so the first cycle after release looks like a
  // gap and the first strobe lands one cycle later.
  typedef enum logic [2:0] {
    INIT_STB,
    INIT_GAP,
    IDLE,
    UPD_STB,
    UPD_GAP
  } state_t;

  state_t     state;
  logic [3:0] step;   // index of the next table entry to issue
  logic [7:0] g_q;
  logic [7:0] b_q;
  logic       en_q;

  // Init table: {addr, data} for each step.
  function automatic logic [12:0] init_entry(input logic [3:0] idx);
    logic [12:0] e;
    e = {A_CTRL, 8'h00};
    case (idx)
      4'd0:    e = {A_CTRL, 8'h06};
      4'd1:    e = {A_CR0,  CR0_VAL};
      4'd2:    e = {A_BR,   BR_VAL};
      4'd3:    e = {A_ONR,  ONR_VAL};
      4'd4:    e = {A_OFR,  OFR_VAL};
`ifdef LED_BREATHE_EN
      4'd5:    e = {A_BCRR, BCRR_VAL};
      4'd6:    e = {A_BCFR, BCFR_VAL};
      4'd7:    e = {A_PWRR, 8'h00};
      4'd8:    e = {A_PWRG, 8'h00};
      4'd9:    e = {A_PWRB, 8'h00};
      4'd10:   e = {A_CTRL, 8'h07};
      default: e = {A_CTRL, 8'h00};
`else
      4'd5:    e = {A_PWRR, 8'h00};
      4'd6:    e = {A_PWRG, 8'h00};
      4'd7:    e = {A_PWRB, 8'h00};
      4'd8:    e = {A_CTRL, 8'h07};
      // Unreachable step. The breathe ramps are not programmed in this
      // build, so they appear here masked to zero only.
      default: e = {A_CTRL, (BCRR_VAL | BCFR_VAL) & 8'h00};
`endif
    endcase
    return e;
  endfunction

  // Update writes after the first (PWRR is issued straight from the inputs
  // on the handshake cycle, so step 0 never reaches this table).
  function automatic logic [12:0] upd_entry(input logic [3:0] idx,
                                            input logic [7:0] g,
                                            input logic [7:0] b,
                                            input logic       en);
    logic [12:0] e;
    e = {A_CTRL, 8'h00};
    case (idx)
      4'd1:    e = {A_PWRG, g};
      4'd2:    e = {A_PWRB, b};
      4'd3:    e = {A_CTRL, 5'b0, {3{en}}};
      default: e = {A_CTRL, 8'h00};
    endcase
    return e;
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; a strobe in flight is cut short here and
    // the whole init sequence restarts from step 0.
    if (rst) begin
      state     <= INIT_GAP;
      step      <= 4'd0;
      cmd_ready <= 1'b0;
      busy      <= 1'b1;
      bus_cs    <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 5'h00;
      bus_din   <= 8'h00;
      g_q       <= 8'h00;
      b_q       <= 8'h00;
      en_q      <= 1'b0;
    end else begin
      case (state)
        // A gap is only ever followed by another strobe: completion is
        // decided on the strobe cycle, so the final gap doubles as the
        // first ready cycle.
        INIT_GAP: begin
          {bus_addr, bus_din} <= init_entry(step);
          bus_cs <= 1'b1;
          bus_we <= 1'b1;
          step   <= step + 4'd1;
          state  <= INIT_STB;
        end

        INIT_STB: begin
          bus_cs <= 1'b0;
          bus_we <= 1'b0;
          if (step == INIT_LEN) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            state <= INIT_GAP;
          end
        end

        // cmd_ready is 1 exactly while in IDLE, so valid alone is the
        // handshake here.
        IDLE: begin
          if (cmd_valid) begin
            g_q       <= cmd_g;
            b_q       <= cmd_b;
            en_q      <= cmd_en;
            bus_addr  <= A_PWRR;
            bus_din   <= cmd_r;
            bus_cs    <= 1'b1;
            bus_we    <= 1'b1;
            step      <= 4'd1;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= UPD_STB;
          end
        end

        UPD_GAP: begin
          {bus_addr, bus_din} <= upd_entry(step, g_q, b_q, en_q);
          bus_cs <= 1'b1;
          bus_we <= 1'b1;
          step   <= step + 4'd1;
          state  <= UPD_STB;
        end

        UPD_STB: begin
          bus_cs <= 1'b0;
          bus_we <= 1'b0;
          if (step == UPD_LEN) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            state <= UPD_GAP;
          end
        end

        default: begin
          bus_cs    <= 1'b0;
          bus_we    <= 1'b0;
          step      <= 4'd0;
          cmd_ready <= 1'b0;
          busy      <= 1'b1;
          state     <= INIT_GAP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_seq_master.sv
// ----------------------------------------------------------------------------
// tb_rgb_seq_master
//
// Scoreboard bench for rgb_seq_master. Stimulus pushes each expected bus
// write (addr, data, cycle number) into a queue; a monitor on the falling
// edge pops and compares whenever bus_cs is high. Cycle numbers count rising
// edges, so the cycle during which rst is first sampled low is that
// sequence's cycle 0.
// ----------------------------------------------------------------------------
module tb_rgb_seq_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_r = 8'h00;
  logic [7:0] cmd_g = 8'h00;
  logic [7:0] cmd_b = 8'h00;
  logic       cmd_en = 1'b0;
  logic       cmd_ready;
  logic       busy;
  logic       bus_cs;
  logic       bus_we;
  logic [4:0] bus_addr;
  logic [7:0] bus_din;

  rgb_seq_master dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_r     (cmd_r),
    .cmd_g     (cmd_g),
    .cmd_b     (cmd_b),
    .cmd_en    (cmd_en),
    .busy      (busy),
    .bus_cs    (bus_cs),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_din   (bus_din)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] din;
    int         at;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Hand-computed init table with the default parameter values.
`ifdef LED_BREATHE_EN
  localparam int INIT_N = 11;
  logic [12:0] init_tbl[INIT_N] = '{
    {5'h00, 8'h06}, {5'h18, 8'h81}, {5'h19, 8'h76}, {5'h1A, 8'h00},
    {5'h1B, 8'h00}, {5'h15, 8'h00}, {5'h16, 8'h00}, {5'h11, 8'h00},
    {5'h12, 8'h00}, {5'h13, 8'h00}, {5'h00, 8'h07}};
`else
  localparam int INIT_N = 9;
  logic [12:0] init_tbl[INIT_N] = '{
    {5'h00, 8'h06}, {5'h18, 8'h81}, {5'h19, 8'h76}, {5'h1A, 8'h00},
    {5'h1B, 8'h00}, {5'h11, 8'h00}, {5'h12, 8'h00}, {5'h13, 8'h00},
    {5'h00, 8'h07}};
`endif

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_write(input logic [4:0] addr, input logic [7:0] din,
                            input int at);
    wr_t w;
    w.addr = addr;
    w.din  = din;
    w.at   = at;
    exp_q.push_back(w);
  endtask

  task automatic push_init(input int c0);
    for (int i = 0; i < INIT_N; i++) begin
      logic [12:0] e;
      e = init_tbl[i];
      push_write(e[12:8], e[7:0], c0 + 1 + 2 * i);
    end
  endtask

  // Waits (bounded) for cmd_ready, sampling from the next falling edge on.
  // Returns at the falling edge where it was seen.
  task automatic wait_ready(input int exp_cyc, input string name);
    int seen;
    seen = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        seen = cyc;
        break;
      end
    end
    check(name, seen, exp_cyc);
    if (seen >= 0) check({name, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  // Presents a command at the current falling edge (cmd_ready already seen
  // high) and queues the four writes it must produce.
  task automatic send_cmd(input logic [7:0] r, input logic [7:0] g,
                          input logic [7:0] b, input logic en, output int t);
    cmd_r     = r;
    cmd_g     = g;
    cmd_b     = b;
    cmd_en    = en;
    cmd_valid = 1'b1;
    t = cyc;
    push_write(5'h11, r, t + 1);
    push_write(5'h12, g, t + 3);
    push_write(5'h13, b, t + 5);
    push_write(5'h00, en ? 8'h07 : 8'h00, t + 7);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs"},    {31'b0, bus_cs},    32'd0);
    check({tag, "_we"},    {31'b0, bus_we},    32'd0);
    check({tag, "_addr"},  {27'b0, bus_addr},  32'd0);
    check({tag, "_din"},   {24'b0, bus_din},   32'd0);
    check({tag, "_ready"}, {31'b0, cmd_ready}, 32'd0);
    check({tag, "_busy"},  {31'b0, busy},      32'd1);
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (bus_cs === 1'b1 || bus_we === 1'b1)
      check("we_eq_cs", {31'b0, bus_we}, {31'b0, bus_cs});
    if (bus_cs === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: addr=0x%0h din=0x%0h at cycle %0d, none expected",
                 bus_addr, bus_din, cyc);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr",  {27'b0, bus_addr}, {27'b0, e.addr});
        check("wr_din",   {24'b0, bus_din},  {24'b0, e.din});
        check("wr_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int t;

    // 1/2: reset, then the init sequence.
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    c0  = cyc;
    push_init(c0);
    wait_ready(c0 + 2 * INIT_N, "init_ready");

    // 3: enabled colour command; inputs change right after capture.
    send_cmd(8'h40, 8'h80, 8'hFF, 1'b1, t);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_r = 8'hEE; cmd_g = 8'hDD; cmd_b = 8'hCC; cmd_en = 1'b0;
    wait_ready(t + 8, "cmd1_ready");

    // Idle a few cycles with valid low: no strobes expected.
    repeat (3) @(negedge clk);
    check("idle_ready", {31'b0, cmd_ready}, 32'd1);

    // 4: LED-off command.
    send_cmd(8'h12, 8'h34, 8'h56, 1'b0, t);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_ready(t + 8, "cmd2_ready");

    // 5: valid held high with changing data during the update.
    send_cmd(8'hA1, 8'hB2, 8'hC3, 1'b1, t);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      cmd_r  = 8'(k);
      cmd_g  = 8'(k * 3);
      cmd_b  = 8'(k * 7);
      cmd_en = k[0];
    end
    @(negedge clk);
    cmd_r = 8'h5A; cmd_g = 8'hA5; cmd_b = 8'h3C; cmd_en = 1'b0;
    wait_ready(t + 8, "cmd3_ready");
    push_write(5'h11, 8'h5A, t + 9);
    push_write(5'h12, 8'hA5, t + 11);
    push_write(5'h13, 8'h3C, t + 13);
    push_write(5'h00, 8'h00, t + 15);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_ready(t + 16, "cmd4_ready");

    // 6: reset pulsed during the PWRG strobe of an update.
    send_cmd(8'h11, 8'h22, 8'h33, 1'b1, t);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    rst = 1'b0;
    c0 = t + 4;
    push_init(c0);
    wait_ready(c0 + 2 * INIT_N, "reinit_ready");

    repeat (4) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
